// File: rtl/i2c_target.sv
// I2C target with a byte-addressed register file: 7-bit addressing, pointer
// writes, auto-incrementing burst reads/writes, repeated START, no stretching.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h1D,
  parameter int         REG_AW      = 4,
  parameter int         ID_REG_ADDR = 0,
  parameter logic [7:0] ID_VALUE    = 8'hE5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic              ext_we,
  input  logic [REG_AW-1:0] ext_addr,
  input  logic [7:0]        ext_data,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int                NUM_REGS = 1 << REG_AW;
  localparam logic [REG_AW-1:0] ID_ADDR  = REG_AW'(ID_REG_ADDR);
  localparam logic [REG_AW-1:0] PTR_ONE  = REG_AW'(1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT
  } state_t;

  logic scl_q1, scl_q2, scl_q3, sda_q1, sda_q2, sda_q3;
  logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

  state_t            state, state_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [6:0]        shift, shift_nxt;
  logic [7:0]        tx, tx_nxt;
  logic              rw, rw_nxt;
  logic [REG_AW-1:0] ptr, ptr_nxt;
  logic              sda_oe_nxt, busy_nxt, wr_strobe_nxt;
  logic [REG_AW-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic              reg_we;
  logic [7:0]        regs [NUM_REGS];
  logic [7:0]        rx_byte, rd_byte;

  assign rx_byte = {shift, sda_bit};
  assign rd_byte = (ptr == ID_ADDR) ? ID_VALUE : regs[ptr];

  // Pin synchronizers plus registered bus events (3 clk pin-to-detection).
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_q1, scl_q2, scl_q3} <= 3'b111;
      {sda_q1, sda_q2, sda_q3} <= 3'b111;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_bit   <= 1'b1;
    end else begin
      {scl_q3, scl_q2, scl_q1} <= {scl_q2, scl_q1, scl_i};
      {sda_q3, sda_q2, sda_q1} <= {sda_q2, sda_q1, sda_i};
      scl_rise  <= scl_q2 & ~scl_q3;
      scl_fall  <= ~scl_q2 & scl_q3;
      start_det <= scl_q2 & scl_q3 & ~sda_q2 & sda_q3;
      stop_det  <= scl_q2 & scl_q3 & sda_q2 & ~sda_q3;
      sda_bit   <= sda_q2;
    end
  end

  // Protocol state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 7'd0;
      tx        <= 8'd0;
      rw        <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      tx        <= tx_nxt;
      rw        <= rw_nxt;
      ptr       <= ptr_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      wr_strobe <= wr_strobe_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
    end
  end

  // Next-state logic; START/STOP override whatever the FSM is doing.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    tx_nxt        = tx;
    rw_nxt        = rw;
    ptr_nxt       = ptr;
    sda_oe_nxt    = sda_oe;
    busy_nxt      = busy;
    wr_strobe_nxt = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    reg_we        = 1'b0;
    if (start_det || stop_det) begin
      state_nxt   = start_det ? ST_ADDR : ST_IDLE;
      busy_nxt    = start_det;
      bit_cnt_nxt = 4'd0;
      shift_nxt   = 7'd0;
      sda_oe_nxt  = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise && bit_cnt != 4'd7) begin
            shift_nxt   = rx_byte[6:0];
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_rise) begin
            bit_cnt_nxt = 4'd0;
            shift_nxt   = 7'd0;
            case (state)
              ST_ADDR: begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_nxt    = rx_byte[0];
                  state_nxt = ST_ADDR_ACK;
                end else begin
                  state_nxt = ST_WAIT;
                end
              end
              ST_REG: begin
                ptr_nxt   = rx_byte[REG_AW-1:0];
                state_nxt = ST_REG_ACK;
              end
              default: begin
                // The ID register swallows writes silently but still ACKs.
                if (ptr != ID_ADDR) begin
                  reg_we        = 1'b1;
                  wr_strobe_nxt = 1'b1;
                  wr_addr_nxt   = ptr;
                  wr_data_nxt   = rx_byte;
                end else begin
                  reg_we = 1'b0;
                end
                ptr_nxt   = ptr + PTR_ONE;
                state_nxt = ST_WDATA_ACK;
              end
            endcase
          end else begin
            state_nxt = state;
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall && !sda_oe) begin
            sda_oe_nxt = 1'b1;
          end else if (scl_fall) begin
            sda_oe_nxt = 1'b0;
            case (state)
              ST_ADDR_ACK: begin
                if (rw) begin
                  state_nxt   = ST_RDATA;
                  tx_nxt      = {rd_byte[6:0], 1'b0};
                  sda_oe_nxt  = ~rd_byte[7];
                  bit_cnt_nxt = 4'd1;
                end else begin
                  state_nxt = ST_REG;
                end
              end
              default: state_nxt = ST_WDATA;
            endcase
          end else begin
            state_nxt = state;
          end
        end
        ST_RDATA: begin
          // bit_cnt counts bits already presented; 0 means load on this fall.
          if (scl_fall && bit_cnt == 4'd0) begin
            tx_nxt      = {rd_byte[6:0], 1'b0};
            sda_oe_nxt  = ~rd_byte[7];
            bit_cnt_nxt = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 4'd0;
            state_nxt   = ST_RDATA_ACK;
          end else if (scl_fall) begin
            sda_oe_nxt  = ~tx[7];
            tx_nxt      = {tx[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else begin
            state_nxt = state;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise && !sda_bit) begin
            ptr_nxt   = ptr + PTR_ONE;
            state_nxt = ST_RDATA;
          end else if (scl_rise) begin
            state_nxt = ST_WAIT;
          end else begin
            state_nxt = state;
          end
        end
        ST_IDLE, ST_WAIT: state_nxt = state;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  // Register file; an I2C write beats a fabric write to the same address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'd0;
      end
    end else begin
      if (ext_we && !(reg_we && ext_addr == ptr)) begin
        regs[ext_addr] <= ext_data;
      end
      if (reg_we) begin
        regs[ptr] <= rx_byte;
      end
    end
  end

endmodule
